// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full_adder cell adds two WIDTH-bit operands
// LSB first, one bit per clock, with the carry held in a flop between bits.
// Optional feature macro: SERIAL_ADD_OVF_EN adds a registered signed-overflow output Ovf.

// Single-bit full adder cell time-shared by the controller.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             Ready,
    output logic             Busy,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Done
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             fa_s;
    logic             fa_cout;
    logic             last_bit;

    full_adder u_fa (
        .A    (a_sh[0]),
        .B    (b_sh[0]),
        .Cin  (carry),
        .S    (fa_s),
        .Cout (fa_cout)
    );

    assign last_bit = (cnt == LAST);

    // State register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_n = state;
        Ready   = 1'b0;
        Busy    = 1'b0;
        case (state)
            IDLE: begin
                Ready = 1'b1;
                if (Start) state_n = ADD;
            end
            ADD: begin
                Busy = 1'b1;
                if (last_bit) state_n = DONE;
            end
            DONE: begin
                Busy    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Operand load, per-bit shift/carry update and final result capture.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt    <= '0;
            carry  <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            S      <= '0;
            Cout   <= 1'b0;
            Done   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            Ovf    <= 1'b0;
`endif
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        carry <= Cin;
                        cnt   <= '0;
                    end
                end
                ADD: begin
                    carry  <= fa_cout;
                    sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
                    a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        // The MSB sum bit is still on the adder output this cycle,
                        // so S is assembled from it plus the partially shifted sum.
                        S    <= {fa_s, sum_sh[WIDTH-1:1]};
                        Cout <= fa_cout;
                        Done <= 1'b1;
`ifdef SERIAL_ADD_OVF_EN
                        // carry flop holds the carry into the MSB on the last bit
                        Ovf  <= carry ^ fa_cout;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed adds, a scoreboard of
// expected results popped on each Done pulse, latency, busy-start and mid-add reset.
// Covers the SERIAL_ADD_OVF_EN output when that macro is defined.
`timescale 1ns/1ps

module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    logic         Clk;
    logic         Rst_n;
    logic         Start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         Ready;
    logic         Busy;
    logic [W-1:0] S;
    logic         Cout;
    logic         Done;
`ifdef SERIAL_ADD_OVF_EN
    logic         Ovf;
`endif

    serial_add_ctrl #(.WIDTH(W)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .Start (Start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .Ready (Ready),
        .Busy  (Busy),
        .S     (S),
        .Cout  (Cout),
        .Done  (Done)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .Ovf   (Ovf)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    int unsigned done_cnt = 0;

    // Expected {Ovf, Cout, S}
    logic [W+1:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every Done pulse must match the oldest outstanding expectation.
    always @(negedge Clk) begin
        logic [W+1:0] e;
        if (Rst_n === 1'b1 && Done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sum", 32'(S), 32'(e[W-1:0]));
                chk("cout", 32'(Cout), 32'(e[W]));
`ifdef SERIAL_ADD_OVF_EN
                chk("ovf", 32'(Ovf), 32'(e[W+1]));
`endif
            end
        end
    end

    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W:0] t;
        logic       v;
        t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        v = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
        return {v, t};
    endfunction

    // One add: optional one-cycle Start pulse k cycles into the add (0 = none).
    task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                           input int unsigned intrude_at);
        int unsigned n;
        int unsigned d0;
        @(negedge Clk);
        chk("ready_before", 32'(Ready), 32'd1);
        A = a; B = b; Cin = c; Start = 1'b1;
        sb.push_back(model(a, b, c));
        d0 = done_cnt;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
        chk("busy_after_accept", 32'(Busy), 32'd1);
        n = 0;
        while (Done !== 1'b1 && n < 20) begin
            if (intrude_at != 0 && n == intrude_at) begin
                Start = 1'b1; A = 8'h11; B = 8'h22;
            end else begin
                Start = 1'b0;
            end
            @(posedge Clk);
            #1;
            n++;
        end
        Start = 1'b0;
        chk("done_latency", n, W);
        @(posedge Clk);
        #1;
        chk("ready_after_done", 32'(Ready), 32'd1);
        chk("done_one_cycle", 32'(Done), 32'd0);
        #6;
        chk("one_done_pulse", done_cnt - d0, 32'd1);
    endtask

    initial begin
        int unsigned d0;
        Rst_n = 1'b0; Start = 1'b0; A = '0; B = '0; Cin = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        chk("rst_ready", 32'(Ready), 32'd1);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_s", 32'(S), 32'h00);
        chk("rst_cout", 32'(Cout), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);

        run_add(8'h5A, 8'h3C, 1'b0, 0);
        run_add(8'hFF, 8'h01, 1'b0, 0);
        run_add(8'hFF, 8'hFF, 1'b1, 0);
        run_add(8'h01, 8'h02, 1'b0, 3);
        chk("ignored_start_s", 32'(S), 32'h03);

        // Reset 4 cycles into an add: no Done, outputs cleared.
        @(negedge Clk);
        A = 8'h77; B = 8'h66; Cin = 1'b1; Start = 1'b1;
        d0 = done_cnt;
        @(posedge Clk);
        #1 Start = 1'b0;
        repeat (4) @(posedge Clk);
        #1 Rst_n = 1'b0;
        #1;
        chk("abort_s", 32'(S), 32'h00);
        chk("abort_cout", 32'(Cout), 32'd0);
        chk("abort_done", 32'(Done), 32'd0);
        chk("abort_busy", 32'(Busy), 32'd0);
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        repeat (12) @(negedge Clk);
        chk("abort_no_done", done_cnt - d0, 32'd0);
        chk("abort_idle_ready", 32'(Ready), 32'd1);

        run_add(8'h10, 8'h20, 1'b0, 0);
        chk("fresh_s", 32'(S), 32'h30);

`ifdef SERIAL_ADD_OVF_EN
        run_add(8'h7F, 8'h01, 1'b0, 0);
        run_add(8'h80, 8'h80, 1'b0, 0);
        run_add(8'h05, 8'h03, 1'b0, 0);
`endif
        for (int i = 0; i < 4; i++) begin
            run_add(W'($urandom), W'($urandom), 1'($urandom), 0);
        end

        repeat (3) @(negedge Clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Hard bound on total run time.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
